// File: rtl/dpi_pkg.sv
// Shared widths, FSM encoding and pipeline-gap minimums for the DPI front-end sequencer.
package dpi_pkg;

  localparam int STREAM_ID_W = 6;
  localparam int NUM_STREAMS = 64;
  localparam int FLOW_KEY_W  = 32;
  localparam int CHAR_W      = 8;

  localparam int DPI_MIN_LOAD_GAP = 2;
  localparam int DPI_MIN_DRAIN    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_LOAD,
    ST_GAP,
    ST_STREAM,
    ST_DRAIN,
    ST_EOP
  } seq_state_e;

  // A too-small gap would let bytes reach the DFA before the restored state does.
  function automatic int dpi_at_least(input int value, input int floor_value);
    return (value < floor_value) ? floor_value : value;
  endfunction

endpackage

// File: rtl/dpi_flow_table.sv
// 64-entry flow key table: parallel compare with lowest-index priority, round-robin allocation.
module dpi_flow_table
  import dpi_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_req_i,
  input  logic [FLOW_KEY_W-1:0]  lookup_key_i,
  output logic                   hit_o,
  output logic [STREAM_ID_W-1:0] hit_idx_o,
  input  logic                   alloc_i,
  output logic [STREAM_ID_W-1:0] alloc_idx_o
);

  logic [NUM_STREAMS-1:0] valid_q;
  logic [FLOW_KEY_W-1:0]  keys_q [NUM_STREAMS];
  logic [STREAM_ID_W-1:0] alloc_ptr_q;
  logic [NUM_STREAMS-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_cmp
      assign match[gi] = valid_q[gi] & (keys_q[gi] == lookup_key_i);
    end
  endgenerate

  always_comb begin
    hit_idx_o = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (match[i]) hit_idx_o = STREAM_ID_W'(i);
    end
  end

  assign hit_o       = lookup_req_i & (|match);
  assign alloc_idx_o = alloc_ptr_q;

  // Pointer is exactly 6 bits wide, so 63 -> 0 wraps for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      alloc_ptr_q <= '0;
    end else if (alloc_i) begin
      valid_q[alloc_ptr_q] <= 1'b1;
      alloc_ptr_q          <= alloc_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_i) keys_q[alloc_ptr_q] <= lookup_key_i;
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Packet front-end: maps flows to stream ids and sequences load/gap/bytes/drain/eop to the matchers.
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int LOAD_GAP = 2,
  parameter int DRAIN    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHAR_W-1:0]      pkt_data,
  input  logic                   pkt_vld,
  input  logic                   pkt_sop,
  input  logic                   pkt_eop,
  input  logic [FLOW_KEY_W-1:0]  pkt_flow_key,
  output logic                   pkt_rdy,
  input  logic [NUM_STREAMS-1:0] cfg_enable_mask,
  output logic [CHAR_W-1:0]      char_in,
  output logic                   char_in_vld,
  output logic                   load_state,
  output logic                   new_stream_id,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic                   enable,
  output logic                   eop,
  output logic [31:0]            pkt_count,
  output logic [15:0]            new_flow_count,
  output logic [15:0]            drop_count
);

  localparam int          GAP_N      = dpi_at_least(LOAD_GAP, DPI_MIN_LOAD_GAP);
  localparam int          DRAIN_N    = dpi_at_least(DRAIN, DPI_MIN_DRAIN);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_N - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_N - 1);

  seq_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [FLOW_KEY_W-1:0] key_q;
  logic [STREAM_ID_W-1:0] sid_q;
  logic new_q, en_q;
  logic [31:0] pkt_count_q;
  logic [15:0] new_flow_count_q, drop_count_q;

  logic lookup_req, tbl_hit, tbl_alloc;
  logic [STREAM_ID_W-1:0] hit_idx, alloc_idx, sel_idx;

  dpi_flow_table u_flow_table (
    .clk          (clk),
    .rst          (rst),
    .lookup_req_i (lookup_req),
    .lookup_key_i (key_q),
    .hit_o        (tbl_hit),
    .hit_idx_o    (hit_idx),
    .alloc_i      (tbl_alloc),
    .alloc_idx_o  (alloc_idx)
  );

  assign lookup_req = (state_q == ST_LOOKUP);
  assign sel_idx    = tbl_hit ? hit_idx : alloc_idx;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pkt_rdy     = 1'b0;
    char_in     = '0;
    char_in_vld = 1'b0;
    load_state  = 1'b0;
    eop         = 1'b0;
    tbl_alloc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The sop beat is left on the bus; it becomes the first byte in STREAM.
        pkt_rdy = pkt_vld & ~pkt_sop;
        if (pkt_vld && pkt_sop) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        tbl_alloc = ~tbl_hit;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        load_state = 1'b1;
        cnt_d      = '0;
        state_d    = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ST_STREAM;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      ST_STREAM: begin
        pkt_rdy = 1'b1;
        if (pkt_vld) begin
          char_in     = pkt_data;
          char_in_vld = 1'b1;
          if (pkt_eop) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = ST_EOP;
        else                     cnt_d   = cnt_q + 16'd1;
      end
      ST_EOP: begin
        eop     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      key_q            <= '0;
      sid_q            <= '0;
      new_q            <= 1'b0;
      en_q             <= 1'b0;
      pkt_count_q      <= '0;
      new_flow_count_q <= '0;
      drop_count_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && pkt_vld && pkt_sop) key_q <= pkt_flow_key;
      if (state_q == ST_LOOKUP) begin
        sid_q <= sel_idx;
        new_q <= ~tbl_hit;
        en_q  <= cfg_enable_mask[sel_idx];
        if (!tbl_hit && new_flow_count_q != 16'hFFFF) new_flow_count_q <= new_flow_count_q + 16'd1;
      end
      if (state_q == ST_IDLE && pkt_vld && !pkt_sop && drop_count_q != 16'hFFFF)
        drop_count_q <= drop_count_q + 16'd1;
      if (state_q == ST_EOP && pkt_count_q != 32'hFFFF_FFFF)
        pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign stream_id      = sid_q;
  assign new_stream_id  = new_q;
  assign enable         = en_q;
  assign pkt_count      = pkt_count_q;
  assign new_flow_count = new_flow_count_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Randomised scoreboard bench: driver pushes expected packets/bytes, negedge monitor pops and checks.
module tb_dpi_stream_sequencer;
  import dpi_pkg::*;

  localparam int LOAD_GAP = 2;
  localparam int DRAIN    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pkt_data;
  logic        pkt_vld, pkt_sop, pkt_eop, pkt_rdy;
  logic [31:0] pkt_flow_key;
  logic [63:0] cfg_enable_mask;
  logic [7:0]  char_in;
  logic        char_in_vld, load_state, new_stream_id, enable, eop;
  logic [5:0]  stream_id;
  logic [31:0] pkt_count;
  logic [15:0] new_flow_count, drop_count;

  always #5 clk = ~clk;

  dpi_stream_sequencer #(.LOAD_GAP(LOAD_GAP), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop),
    .pkt_eop(pkt_eop), .pkt_flow_key(pkt_flow_key), .pkt_rdy(pkt_rdy),
    .cfg_enable_mask(cfg_enable_mask), .char_in(char_in), .char_in_vld(char_in_vld),
    .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
    .enable(enable), .eop(eop), .pkt_count(pkt_count), .new_flow_count(new_flow_count),
    .drop_count(drop_count)
  );

  typedef struct {
    int sid;
    bit is_new;
    bit en;
    int sop_cyc;
    int nbytes;
  } exp_pkt_t;

  exp_pkt_t   exp_q[$];
  logic [7:0] exp_bytes[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  int eops_seen = 0;
  logic [7:0] pkt_buf [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
  endtask

  // Reference flow table: list of (valid,key) slots with a round-robin victim pointer.
  logic [31:0] m_keys [64];
  bit          m_valid[64];
  int m_ptr, m_pkts, m_newf, m_drops;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    m_ptr = 0; m_pkts = 0; m_newf = 0; m_drops = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] key, output int sid, output bit is_new);
    sid = -1;
    for (int i = 0; i < 64; i++) if (sid < 0 && m_valid[i] && m_keys[i] == key) sid = i;
    is_new = (sid < 0);
    if (is_new) begin
      sid = m_ptr;
      m_keys[sid] = key;
      m_valid[sid] = 1;
      m_ptr = (m_ptr + 1) % 64;
      if (m_newf < 65535) m_newf++;
    end
  endfunction

  // Monitor
  exp_pkt_t cur;
  bit active = 0;
  int load_cyc, last_char, nchars;

  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else begin
      if (load_state) begin
        if (exp_q.size() == 0) unexpected("spurious_load_state");
        else begin
          cur = exp_q.pop_front();
          active = 1; load_cyc = cyc; nchars = 0; last_char = -1;
          chk("load_latency", 64'(cyc), 64'(cur.sop_cyc + 2));
          $display("pkt load cyc=%0d sid=%0d new=%0b en=%0b", cyc, stream_id, new_stream_id, enable);
        end
      end
      if (active) begin
        chk("stream_id", 64'(stream_id), 64'(cur.sid));
        chk("new_stream_id", 64'(new_stream_id), 64'(cur.is_new));
        chk("enable", 64'(enable), 64'(cur.en));
      end
      if (char_in_vld) begin
        if (!active) unexpected("char_outside_packet");
        else begin
          if (nchars == 0) chk("first_char_latency", 64'(cyc), 64'(load_cyc + LOAD_GAP + 1));
          if (exp_bytes.size() == 0) unexpected("extra_char");
          else chk("char_in", 64'(char_in), 64'(exp_bytes.pop_front()));
          nchars++; last_char = cyc;
        end
      end
      if (eop) begin
        if (!active) unexpected("spurious_eop");
        else begin
          chk("eop_latency", 64'(cyc), 64'(last_char + DRAIN + 1));
          chk("char_count", 64'(nchars), 64'(cur.nbytes));
          $display("pkt eop  cyc=%0d chars=%0d", cyc, nchars);
          active = 0;
        end
        eops_seen++;
      end
    end
  end

  // Driver
  task automatic do_reset();
    rst = 1; pkt_vld = 0; pkt_sop = 0; pkt_eop = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    exp_q.delete(); exp_bytes.delete();
  endtask

  task automatic send_pkt(input logic [31:0] key, input int len, input int bub_pct, input bit full);
    int sid; bit is_new; bit accepted; int budget;
    model_lookup(key, sid, is_new);
    exp_q.push_back('{sid: sid, is_new: is_new, en: cfg_enable_mask[sid], sop_cyc: cyc, nbytes: len});
    for (int i = 0; i < len; i++) begin
      if (i > 0 && $urandom_range(0, 99) < bub_pct) begin
        pkt_vld = 0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      pkt_vld = 1; pkt_sop = (i == 0); pkt_eop = full && (i == len - 1);
      pkt_data = pkt_buf[i]; pkt_flow_key = key;
      exp_bytes.push_back(pkt_buf[i]);
      accepted = 0; budget = 0;
      while (!accepted && budget < 100) begin
        @(negedge clk);
        if (pkt_rdy) accepted = 1;
        @(posedge clk); #1;
        budget++;
      end
      if (!accepted) unexpected("beat_accept_timeout");
    end
    pkt_vld = 0; pkt_sop = 0; pkt_eop = 0;
  endtask

  task automatic wait_eop(input int target);
    int n = 0;
    while (eops_seen < target && n < 300) begin
      @(posedge clk); n++;
    end
    #1;
    if (eops_seen < target) unexpected("eop_timeout");
    else m_pkts++;
    chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
    chk("new_flow_count", 64'(new_flow_count), 64'(m_newf));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  task automatic run_pkt(input logic [31:0] key, input int len, input int bub_pct);
    int target;
    target = eops_seen + 1;
    send_pkt(key, len, bub_pct, 1);
    wait_eop(target);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) pkt_buf[i] = 8'($urandom);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_char_in_vld"}, 64'(char_in_vld), 64'd0);
    chk({tag, "_load_state"}, 64'(load_state), 64'd0);
    chk({tag, "_eop"}, 64'(eop), 64'd0);
    chk({tag, "_stream_id"}, 64'(stream_id), 64'd0);
    chk({tag, "_new_stream_id"}, 64'(new_stream_id), 64'd0);
    chk({tag, "_enable"}, 64'(enable), 64'd0);
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
    chk({tag, "_new_flow_count"}, 64'(new_flow_count), 64'd0);
    chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
  endtask

  logic [31:0] key_pool [6];

  initial begin
    int eops_before;
    pkt_data = 0; pkt_flow_key = 0; cfg_enable_mask = 64'h0;
    do_reset();
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_pkt_rdy", 64'(pkt_rdy), 64'd0);
    @(posedge clk); #1;

    // "abc" on a fresh flow, then the same flow again
    pkt_buf[0] = 8'h61; pkt_buf[1] = 8'h62; pkt_buf[2] = 8'h63;
    run_pkt(32'hAABB0001, 3, 0);
    run_pkt(32'hAABB0001, 3, 0);

    // Per-stream enable mask
    cfg_enable_mask = 64'h2;
    fill_random(4); run_pkt(32'hAABB0002, 4, 0);
    fill_random(2); run_pkt(32'hAABB0001, 2, 0);

    // Stray non-sop beats in IDLE
    for (int i = 0; i < 3; i++) begin
      pkt_vld = 1; pkt_sop = 0; pkt_eop = (i == 2); pkt_data = 8'($urandom);
      @(negedge clk);
      chk("drop_pkt_rdy", 64'(pkt_rdy), 64'd1);
      @(posedge clk); #1;
      m_drops++;
      $display("drop beat %0d", i);
    end
    pkt_vld = 0; pkt_eop = 0;
    repeat (3) @(posedge clk); #1;
    chk("drop_count_after_drops", 64'(drop_count), 64'(m_drops));

    // Randomised packets with bubbles, repeating flows and random masks
    for (int i = 0; i < 6; i++) key_pool[i] = $urandom;
    for (int p = 0; p < 14; p++) begin
      int len;
      cfg_enable_mask = {$urandom, $urandom};
      len = $urandom_range(1, 8);
      fill_random(len);
      run_pkt(key_pool[$urandom_range(0, 5)], len, 40);
    end

    // Table wrap: 65 distinct keys, then the first one has been evicted
    do_reset();
    cfg_enable_mask = 64'h8000_0000_0000_0001;
    pkt_buf[0] = 8'h5A;
    run_pkt(32'hAABB0001, 1, 0);
    for (int i = 1; i < 65; i++) run_pkt(32'h1000_0000 + i, 1, 0);
    run_pkt(32'hAABB0001, 1, 0);

    // Reset in the middle of STREAM aborts the packet
    fill_random(3);
    send_pkt(32'h00C0FFEE, 3, 0, 0);
    rst = 1; pkt_vld = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle_outputs("abort");
    @(posedge clk); #1 rst = 0;
    model_reset(); exp_q.delete(); exp_bytes.delete();
    eops_before = eops_seen;
    repeat (20) @(posedge clk); #1;
    chk("abort_no_eop", 64'(eops_seen), 64'(eops_before));
    fill_random(2);
    run_pkt(32'h00C0FFEE, 2, 0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
